// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory read port plus decode-stage handshake.
// master = fetch unit, slave = memory/decode environment.
interface ifetch_unit_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic [15:0]       instr;
  logic [15:0]       imm_word;
  logic              two_word;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_accept;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              fault;

  modport master (
    output mem_addr, mem_req, instr, imm_word, two_word, instr_pc, instr_valid, fault,
    input  mem_ack, mem_rdata, instr_accept, branch_en, branch_target
  );

  modport slave (
    input  mem_addr, mem_req, instr, imm_word, two_word, instr_pc, instr_valid, fault,
    output mem_ack, mem_rdata, instr_accept, branch_en, branch_target
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: assembles one/two-word instructions, handles redirects.
// Optional macro IFETCH_ALIGN_CHECK_EN enables odd-branch-target fault detection.
`ifndef OPC_MOVB_R0
`define OPC_MOVB_R0 8'hB0
`endif
`ifndef OPC_MOVB_R7
`define OPC_MOVB_R7 8'hB7
`endif

module ifetch_unit #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master bus
);

  localparam logic [ADDR_W-1:0] STEP1 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(4);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ1  = 3'd1,
    S_REQ2  = 3'd2,
    S_VALID = 3'd3,
    S_DRAIN = 3'd4
`ifdef IFETCH_ALIGN_CHECK_EN
    , S_FAULT = 3'd5
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_req_q;
  logic [15:0]       instr_q;
  logic [15:0]       imm_q;
  logic              two_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              valid_q;
  logic              fault_q;

  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_next_seq;
  logic [7:0]        opc;
  logic              is_two;

  // MOVB immediates live in the low byte, so those opcodes stay one word long.
  assign opc         = bus.mem_rdata[15:8];
  assign is_two      = bus.mem_rdata[15] && !((opc >= `OPC_MOVB_R0) && (opc <= `OPC_MOVB_R7));
  assign pc_next_seq = pc + (two_q ? STEP2 : STEP1);

`ifdef IFETCH_ALIGN_CHECK_EN
  logic bad_br;
  logic fault_go;

  assign tgt    = bus.branch_target;
  assign bad_br = bus.branch_en && bus.branch_target[0];

  // Odd target: enter the fault state once no read is left outstanding.
  always_comb begin
    fault_go = 1'b0;
    case (state)
      S_REQ1, S_REQ2: fault_go = bus.mem_ack && bad_br;
      S_DRAIN:        fault_go = bus.mem_ack && (fault_q || bad_br);
      S_VALID:        fault_go = bad_br;
      default:        fault_go = 1'b0;
    endcase
  end
`else
  logic unused_tgt0;

  assign tgt         = {bus.branch_target[ADDR_W-1:1], 1'b0};
  assign unused_tgt0 = bus.branch_target[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      instr_q    <= 16'h0000;
      imm_q      <= 16'h0000;
      two_q      <= 1'b0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state      <= S_REQ1;
          mem_req_q  <= 1'b1;
          mem_addr_q <= pc;
        end

        S_REQ1, S_REQ2: begin
          if (bus.branch_en) begin
            pc <= tgt;
            // Without an ack the old read must finish before re-issuing.
            if (bus.mem_ack) begin
              state      <= S_REQ1;
              mem_addr_q <= tgt;
            end else begin
              state <= S_DRAIN;
            end
          end else if (bus.mem_ack) begin
            if (state == S_REQ1) begin
              instr_q    <= bus.mem_rdata;
              instr_pc_q <= pc;
              if (is_two) begin
                two_q      <= 1'b1;
                state      <= S_REQ2;
                mem_addr_q <= pc + STEP1;
              end else begin
                two_q     <= 1'b0;
                imm_q     <= 16'h0000;
                state     <= S_VALID;
                mem_req_q <= 1'b0;
                valid_q   <= 1'b1;
              end
            end else begin
              imm_q     <= bus.mem_rdata;
              state     <= S_VALID;
              mem_req_q <= 1'b0;
              valid_q   <= 1'b1;
            end
          end
        end

        S_VALID: begin
          // Redirect wins over a same-cycle accept.
          if (bus.branch_en) begin
            pc         <= tgt;
            valid_q    <= 1'b0;
            state      <= S_REQ1;
            mem_req_q  <= 1'b1;
            mem_addr_q <= tgt;
          end else if (bus.instr_accept) begin
            pc         <= pc_next_seq;
            valid_q    <= 1'b0;
            state      <= S_REQ1;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_next_seq;
          end
        end

        S_DRAIN: begin
          if (bus.branch_en) begin
            pc <= tgt;
          end
          if (bus.mem_ack) begin
            state      <= S_REQ1;
            mem_addr_q <= bus.branch_en ? tgt : pc;
          end
        end

        default: begin
          state <= state;
        end
      endcase

`ifdef IFETCH_ALIGN_CHECK_EN
      if (bad_br && (state != S_BOOT) && (state != S_FAULT)) begin
        fault_q <= 1'b1;
      end
      if (fault_go) begin
        state     <= S_FAULT;
        mem_req_q <= 1'b0;
        valid_q   <= 1'b0;
      end
`endif
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.instr       = instr_q;
  assign bus.imm_word    = imm_q;
  assign bus.two_word    = two_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with a small wait-programmable memory model.
// Build with or without IFETCH_ALIGN_CHECK_EN; the misaligned-branch check follows the macro.
module tb_ifetch_unit;

  logic clk;
  logic rst_n;

  ifetch_unit_if #(.ADDR_W(16)) bus ();

  ifetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:32767];
  int          wait_cycles;
  int          cnt;
  int          n_cmp;
  int          n_bad;

  // Memory acks once the request has been pending wait_cycles cycles (0 = same cycle).
  assign bus.mem_ack   = bus.mem_req && (cnt >= wait_cycles);
  assign bus.mem_rdata = mem[bus.mem_addr[15:1]];

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic accept_once();
    bus.instr_accept = 1'b1;
    tick();
    bus.instr_accept = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.instr_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("valid_timeout", 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic check_instr(input string tag, input logic [15:0] i, input logic [15:0] imm,
                             input logic two, input logic [15:0] ipc);
    check_eq({tag, "_instr"}, 32'(bus.instr), 32'(i));
    check_eq({tag, "_imm"},   32'(bus.imm_word), 32'(imm));
    check_eq({tag, "_two"},   32'(bus.two_word), 32'(two));
    check_eq({tag, "_pc"},    32'(bus.instr_pc), 32'(ipc));
  endtask

  int n;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    wait_cycles = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[16'h0000 >> 1] = 16'h0102;
    mem[16'h0002 >> 1] = 16'h8203;
    mem[16'h0004 >> 1] = 16'h1234;
    mem[16'h0006 >> 1] = 16'hB312;
    mem[16'h0008 >> 1] = 16'hFFFF;
    mem[16'h0040 >> 1] = 16'h8505;
    mem[16'h0042 >> 1] = 16'h5555;
    mem[16'hFFFE >> 1] = 16'h9001;

    bus.instr_accept  = 1'b0;
    bus.branch_en     = 1'b0;
    bus.branch_target = 16'h0000;
    rst_n = 1'b0;
    tick();
    tick();

    check_eq("rst_req",   32'(bus.mem_req), 32'd0);
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_fault", 32'(bus.fault), 32'd0);
    check_instr("rst", 16'h0000, 16'h0000, 1'b0, 16'h0000);

    rst_n = 1'b1;
    check_eq("boot_req0", 32'(bus.mem_req), 32'd0);
    tick();
    check_eq("boot_req1", 32'(bus.mem_req), 32'd1);
    check_eq("boot_addr", 32'(bus.mem_addr), 32'h0000);

    wait_valid(n);
    check_instr("i0", 16'h0102, 16'h0000, 1'b0, 16'h0000);

    accept_once();
    check_eq("i1_addr", 32'(bus.mem_addr), 32'h0002);
    wait_valid(n);
    check_eq("lat_two", 32'(n), 32'd3);
    check_instr("i1", 16'h8203, 16'h1234, 1'b1, 16'h0002);

    accept_once();
    check_eq("next_addr", 32'(bus.mem_addr), 32'h0006);
    check_eq("next_req",  32'(bus.mem_req), 32'd1);
    wait_valid(n);
    check_eq("lat_one", 32'(n), 32'd2);
    check_instr("movb", 16'hB312, 16'h0000, 1'b0, 16'h0006);

    // Decode stall: everything holds, no fetch traffic.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold_valid", 32'(bus.instr_valid), 32'd1);
      check_eq("hold_instr", 32'(bus.instr), 32'h0000B312);
      check_eq("hold_req",   32'(bus.mem_req), 32'd0);
    end

    // Redirect while the read at 0x0008 is still waiting.
    wait_cycles = 3;
    accept_once();
    check_eq("w_addr", 32'(bus.mem_addr), 32'h0008);
    bus.branch_en     = 1'b1;
    bus.branch_target = 16'h0040;
    tick();
    bus.branch_en = 1'b0;
    check_eq("drain_addr", 32'(bus.mem_addr), 32'h0008);
    check_eq("drain_req",  32'(bus.mem_req), 32'd1);
    for (int i = 0; i < 10 && bus.mem_addr == 16'h0008; i++) begin
      check_eq("drain_novalid", 32'(bus.instr_valid), 32'd0);
      tick();
    end
    check_eq("redir_addr",  32'(bus.mem_addr), 32'h0040);
    check_eq("redir_req",   32'(bus.mem_req), 32'd1);
    check_eq("redir_valid", 32'(bus.instr_valid), 32'd0);

    // Redirect coinciding with the immediate's ack.
    wait_cycles = 0;
    tick();
    check_eq("req2_addr", 32'(bus.mem_addr), 32'h0042);
    bus.branch_en     = 1'b1;
    bus.branch_target = 16'h0040;
    tick();
    bus.branch_en = 1'b0;
    check_eq("req2br_addr",  32'(bus.mem_addr), 32'h0040);
    check_eq("req2br_req",   32'(bus.mem_req), 32'd1);
    check_eq("req2br_valid", 32'(bus.instr_valid), 32'd0);
    wait_valid(n);
    check_instr("i40", 16'h8505, 16'h5555, 1'b1, 16'h0040);

    // Redirect with same-cycle accept: accept ignored, fetch at target.
    bus.branch_en     = 1'b1;
    bus.branch_target = 16'hFFFE;
    bus.instr_accept  = 1'b1;
    tick();
    bus.branch_en    = 1'b0;
    bus.instr_accept = 1'b0;
    check_eq("bva_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("bva_addr",  32'(bus.mem_addr), 32'hFFFE);
    tick();
    check_eq("wrap_imm_addr", 32'(bus.mem_addr), 32'h0000);
    wait_valid(n);
    check_instr("wrap", 16'h9001, 16'h0102, 1'b1, 16'hFFFE);
    accept_once();
    check_eq("wrap_next", 32'(bus.mem_addr), 32'h0002);
    wait_valid(n);
    check_instr("i1b", 16'h8203, 16'h1234, 1'b1, 16'h0002);

    // Odd branch target.
    bus.branch_en     = 1'b1;
    bus.branch_target = 16'h0041;
    tick();
    bus.branch_en = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    check_eq("odd_fault", 32'(bus.fault), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("odd_req",   32'(bus.mem_req), 32'd0);
      check_eq("odd_valid", 32'(bus.instr_valid), 32'd0);
      tick();
    end
    check_eq("odd_fault_sticky", 32'(bus.fault), 32'd1);
`else
    check_eq("odd_fault", 32'(bus.fault), 32'd0);
    check_eq("odd_addr",  32'(bus.mem_addr), 32'h0040);
    check_eq("odd_req",   32'(bus.mem_req), 32'd1);
`endif

    // Reset in the middle of a pending read.
    wait_cycles = 5;
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req",   32'(bus.mem_req), 32'd0);
    check_eq("mid_rst_fault", 32'(bus.fault), 32'd0);
    check_eq("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    wait_cycles = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("reboot_addr", 32'(bus.mem_addr), 32'h0000);
    check_eq("reboot_req",  32'(bus.mem_req), 32'd1);
    wait_valid(n);
    check_instr("reboot", 16'h0102, 16'h0000, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
